aes_key_expand: RTL
===================

# aes_key_expand

Iterative AES-128 key schedule generator for the Encrypt datapath. It takes a 128-bit cipher key and produces the 11 round keys (round 0 through round 10) in order, one at a time, with a valid strobe. It sits directly upstream of `SubWord` and owns one instance of it. Each round, it feeds `SubWord` the four bytes of RotWord(w3) one byte per cycle and consumes the substituted bytes to build the next round key.

## Interface
- No parameters. The block is fixed at AES-128: Nk=4, 10 rounds.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request expansion. Sampled only in IDLE.
- `key_in` in 128: cipher key, sampled on the accepting `start` edge. w0 = `key_in[127:96]`, w3 = `key_in[31:0]`.
- `busy` out 1: expansion in progress. `start` is ignored while high.
- `rk_valid` out 1: one-cycle strobe. `rk_index`/`rk_data` are valid in that cycle.
- `rk_index` out 4: round number 0..10 of the presented key.
- `rk_data` out 128: round key, same word order as `key_in`.
- `done` out 1: one-cycle pulse, coincident with the `rk_valid` for index 10.

## Operation
- States: IDLE, SUB, EXPAND.
- IDLE, `start`=1 → SUB.
  - Load the key register with `key_in` and set rcon=8'h01, byte counter=0.
  - Present round 0: `rk_valid`=1, `rk_index`=0, `rk_data`=`key_in`.
- SUB lasts 4 cycles, counter 0..3.
  - Byte sent to `SubWord`, in order: w3[23:16], w3[15:8], w3[7:0], w3[31:24] (RotWord order).
  - Each result shifts into a 32-bit temp register, first byte landing in `temp[31:24]`.
  - Counter=3 → EXPAND.
- EXPAND lasts 1 cycle.
  - t = temp ^ {rcon, 24'h0}.
  - w4=w0^t, w5=w1^w4, w6=w2^w5, w7=w3^w6.
  - Key register ← {w4,w5,w6,w7}; round counter += 1.
  - Present the new key with `rk_valid`=1.
  - rcon ← xtime(rcon): shift left 1, XOR 8'h1B on carry-out. Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Round counter <10 → SUB with counter=0. Round counter =10 → IDLE and assert `done`.
- `start` while `busy`=1 is ignored. No restart and no re-sampling of `key_in`.
- `rk_data` holds its last value between strobes. Consumers must use `rk_valid` only.
- All arithmetic is XOR and bitwise; there are no width extensions.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `done`=0, `rk_index`=0, `rk_data`=0, state=IDLE, rcon=8'h01, counters=0.
- `rst` overrides everything in the same edge, including mid-expansion. No partial key is emitted afterwards.
- Edge E0: `start` accepted. Round 0 is presented in the cycle after E0, and `busy`=1 from then on.
- Round r (1..10) is presented in the cycle after edge E0+5r. Round 10 appears after E0+50.
- Cycle of round 10: `rk_valid`=1, `done`=1, `busy`=0.
- The next `start` is accepted on edge E0+51 at the earliest. A `start` held high on E0+50 itself is not accepted, because state is still EXPAND there.
- `rk_valid` and `done` are never high for two consecutive cycles within one expansion.
- `SubWord` is combinational: its output is captured on the same edge its input byte is applied. There is no extra latency.
- `key_in` may change freely after E0.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse at E0:
  - index 0 = the key.
  - index 1 = a0fafe1788542cb123a339392a6c7605, in the cycle after E0+5.
  - index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `done`=1, in the cycle after E0+50.
  - Exactly 11 `rk_valid` strobes.
- All-zero key:
  - index 1 = 62636363626363636263636362636363.
  - index 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start while busy: second start with key FF..FF at E0+12 is ignored. The FIPS key outputs are unchanged and the strobe count stays 11.
- Reset mid-op: `rst` at E0+23 → in the next cycle all outputs are 0. A new FIPS start then produces the correct index 1 (proves rcon reset to 01).
- Back-to-back: `start` held high continuously.
  - Accepts are spaced 51 cycles apart: E0, E0+51, E0+102.
  - Each accept produces its own round 0..10 sequence with the correct index-10 value.
- Reset value check: `rst` for 3 cycles with `start`=1 → `busy`, `rk_valid`, `done` all remain 0 throughout.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// Handshake and round-key bus between the AES-128 key schedule and its user.
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] rk_data;
    logic         done;

    modport master (
        output start, key_in,
        input  busy, rk_valid, rk_index, rk_data, done
    );

    modport slave (
        input  start, key_in,
        output busy, rk_valid, rk_index, rk_data, done
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one every 5 cycles,
// pushing RotWord(w3) through a single combinational SubWord byte lane.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. The inverse is a^254, which maps 0 to 0 as required.
module sub_word (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = a;
        e    = 8'hfe;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    logic [7:0] inv;

    // Inverse then affine map with rotations by 1..4 and constant 0x63.
    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic            clk,
    input  logic            rst,
    aes_key_expand_if.slave kx
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SUB    = 2'd1;
    localparam logic [1:0] ST_EXPAND = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  temp_q, temp_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [3:0]   round_q, round_d;
    logic         busy_q, busy_d;
    logic         rk_valid_q, rk_valid_d;
    logic [3:0]   rk_index_q, rk_index_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic         done_q, done_d;

    logic [31:0]  w3;
    logic [7:0]   sub_in;
    logic [7:0]   sub_out;
    logic [31:0]  t, w4, w5, w6, w7;

    sub_word u_sub_word (
        .in_byte  (sub_in),
        .out_byte (sub_out)
    );

    // Byte lane selection in RotWord order and next-round word chain.
    always_comb begin
        w3 = key_q[31:0];
        case (cnt_q)
            2'd0:    sub_in = w3[23:16];
            2'd1:    sub_in = w3[15:8];
            2'd2:    sub_in = w3[7:0];
            default: sub_in = w3[31:24];
        endcase
        t  = temp_q ^ {rcon_q, 24'h000000};
        w4 = key_q[127:96] ^ t;
        w5 = key_q[95:64]  ^ w4;
        w6 = key_q[63:32]  ^ w5;
        w7 = w3            ^ w6;
    end

    // Next-state logic for the IDLE -> SUB x4 -> EXPAND round loop.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        temp_d     = temp_q;
        rcon_d     = rcon_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        busy_d     = busy_q;
        rk_valid_d = 1'b0;
        rk_index_d = rk_index_q;
        rk_data_d  = rk_data_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (kx.start) begin
                    state_d    = ST_SUB;
                    key_d      = kx.key_in;
                    rcon_d     = 8'h01;
                    cnt_d      = 2'd0;
                    round_d    = 4'd0;
                    busy_d     = 1'b1;
                    rk_valid_d = 1'b1;
                    rk_index_d = 4'd0;
                    rk_data_d  = kx.key_in;
                end
            end
            ST_SUB: begin
                temp_d = {temp_q[23:0], sub_out};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                key_d      = {w4, w5, w6, w7};
                round_d    = round_q + 4'd1;
                rk_valid_d = 1'b1;
                rk_index_d = round_q + 4'd1;
                rk_data_d  = {w4, w5, w6, w7};
                rcon_d     = {rcon_q[6:0], 1'b0} ^ ({8{rcon_q[7]}} & 8'h1b);
                cnt_d      = 2'd0;
                if (round_q == 4'd9) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_SUB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            temp_q     <= '0;
            rcon_q     <= 8'h01;
            cnt_q      <= '0;
            round_q    <= '0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_index_q <= '0;
            rk_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            temp_q     <= temp_d;
            rcon_q     <= rcon_d;
            cnt_q      <= cnt_d;
            round_q    <= round_d;
            busy_q     <= busy_d;
            rk_valid_q <= rk_valid_d;
            rk_index_q <= rk_index_d;
            rk_data_q  <= rk_data_d;
            done_q     <= done_d;
        end
    end

    assign kx.busy     = busy_q;
    assign kx.rk_valid = rk_valid_q;
    assign kx.rk_index = rk_index_q;
    assign kx.rk_data  = rk_data_q;
    assign kx.done     = done_q;
endmodule
